// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern type, digit encodings (bit0=a .. bit6=g)
// and the word geometry used by the receiver.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

  localparam int NIBBLES_PER_WORD = 8;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment to hex decoder; blank and illegal patterns are
// reported separately so the caller can treat blank as a separator.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  // Table lookup of the sixteen hex glyphs
  always_comb begin
    legal  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_rx_quantamhd.sv
// Seven-segment receiver: qualifies stable patterns, decodes them to nibbles and
// packs eight nibbles MSN-first into words handed out over a valid/ready port.
module seg7_rx_quantamhd
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segments,
  output logic [3:0]  nibble,
  output logic        nibble_valid,
  output logic [31:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overflow,
  output logic [7:0]  err_count
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [2:0]       LAST_IDX = 3'(NIBBLES_PER_WORD - 1);

  seg_t             seg_q_r;
  seg_t             last_acc_r;
  logic [CNT_W-1:0] stab_cnt_r;
  logic             armed_r;
  logic [2:0]       nib_idx_r;
  logic [27:0]      asm_r;

  logic             dec_legal_s;
  logic             dec_blank_s;
  logic [3:0]       dec_nib_s;
  logic             qual_s;
  logic             take_s;
  logic             bad_s;
  logic             complete_s;
  logic             xfer_s;

  seg7_to_hex u_dec (
    .seg    (seg_q_r),
    .legal  (dec_legal_s),
    .blank  (dec_blank_s),
    .nibble (dec_nib_s)
  );

  // A pattern is accepted once per appearance, and never twice in a row
  assign qual_s     = (stab_cnt_r == STAB_MAX) && armed_r && (seg_q_r != last_acc_r);
  assign take_s     = qual_s && dec_legal_s;
  assign bad_s      = qual_s && !dec_legal_s && !dec_blank_s;
  assign complete_s = take_s && (nib_idx_r == LAST_IDX);
  assign xfer_s     = word_valid && word_ready;

  // Sampling, stability counting and one-shot qualification
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q_r    <= SEG_BLANK;
      stab_cnt_r <= '0;
      armed_r    <= 1'b1;
      last_acc_r <= SEG_BLANK;
    end else begin
      seg_q_r <= segments;
      if (segments == seg_q_r) begin
        stab_cnt_r <= (stab_cnt_r == STAB_MAX) ? stab_cnt_r : stab_cnt_r + CNT_W'(1);
        armed_r    <= qual_s ? 1'b0 : armed_r;
      end else begin
        // a pattern change re-arms even on the qualifying edge itself
        stab_cnt_r <= '0;
        armed_r    <= 1'b1;
      end
      last_acc_r <= qual_s ? seg_q_r : last_acc_r;
    end
  end

  // Nibble output, word assembly and illegal-pattern counting
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble       <= 4'h0;
      nibble_valid <= 1'b0;
      nib_idx_r    <= 3'd0;
      asm_r        <= 28'h0;
      err_count    <= 8'h00;
    end else begin
      nibble_valid <= take_s;
      if (take_s) begin
        nibble    <= dec_nib_s;
        asm_r     <= {asm_r[23:0], dec_nib_s};
        nib_idx_r <= nib_idx_r + 3'd1;
      end
      if (bad_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // Single-entry holding register; a word completing while one is stalled is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      word       <= 32'h0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (complete_s) begin
      if (!word_valid || word_ready) begin
        word       <= {asm_r, dec_nib_s};
        word_valid <= 1'b1;
      end else begin
        overflow   <= 1'b1;
      end
    end else if (xfer_s) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_rx_quantamhd.sv
// Self-checking bench for seg7_rx_quantamhd: directed scenarios plus a randomized
// run compared against a run-length reference model of the receiver.
module tb_seg7_rx_quantamhd;

  localparam int STABLE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  segments = 7'h00;
  logic        word_ready = 1'b0;
  logic [3:0]  nibble;
  logic        nibble_valid;
  logic [31:0] word;
  logic        word_valid;
  logic        overflow;
  logic [7:0]  err_count;

  seg7_rx_quantamhd #(.STABLE_CYCLES(STABLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .segments     (segments),
    .nibble       (nibble),
    .nibble_valid (nibble_valid),
    .word         (word),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .overflow     (overflow),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int failures = 0;

  // Observed traffic, collected away from the active edge
  logic [3:0]  obs_nib [$];
  logic [31:0] obs_xfer [$];
  int          vcount = 0;
  int          nib_mark = 0;
  int          xfer_mark = 0;
  int          v_mark = 0;

  always @(negedge clk) begin
    if (nibble_valid) obs_nib.push_back(nibble);
    if (word_valid && word_ready) obs_xfer.push_back(word);
    if (word_valid) vcount++;
  end

  // Reference model state
  logic [6:0]  m_run_pat, m_last, m_pend_pat;
  int          m_run_len, m_cnt, m_err;
  logic        m_pend, m_hv, m_ovf;
  logic [31:0] m_asm, m_hw;
  logic [3:0]  exp_nib [$];
  logic [31:0] exp_xfer [$];

  function automatic int decode(input logic [6:0] p);
    if (p == 7'h00) return 16;
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_run_pat = 7'h00; m_run_len = 1; m_last = 7'h00; m_pend = 1'b0; m_pend_pat = 7'h00;
    m_cnt = 0; m_err = 0; m_asm = 32'h0; m_hv = 1'b0; m_hw = 32'h0; m_ovf = 1'b0;
    exp_nib.delete(); exp_xfer.delete();
  endtask

  // One clock edge of the reference: results of a pattern accepted on the previous
  // edge appear now; then the current sample extends or restarts the run.
  task automatic model_step();
    logic xfer;
    logic done;
    int   d;
    xfer = m_hv && word_ready;
    done = 1'b0;
    if (m_pend) begin
      d = decode(m_pend_pat);
      if (d < 0) begin
        m_err = (m_err == 255) ? 255 : m_err + 1;
      end else if (d < 16) begin
        exp_nib.push_back(4'(d));
        m_asm = {m_asm[27:0], 4'(d)};
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin done = 1'b1; m_cnt = 0; end
      end
    end
    m_pend = 1'b0;
    if (done) begin
      if (!m_hv || word_ready) begin
        if (xfer) exp_xfer.push_back(m_hw);
        m_hw = m_asm;
        m_hv = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (xfer) begin
      exp_xfer.push_back(m_hw);
      m_hv = 1'b0;
    end
    if (segments == m_run_pat) m_run_len++;
    else begin m_run_pat = segments; m_run_len = 1; end
    if (m_run_len == STABLE + 1 && segments != m_last) begin
      m_last = segments; m_pend = 1'b1; m_pend_pat = segments;
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    segments = p;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
    end
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int count);
    int prev;
    int n;
    prev = -1;
    for (int i = 0; i < count; i++) begin
      n = int'(w[31-4*i -: 4]);
      if (n == prev) hold(7'h00, 10);
      hold(seg_tab[n], 12);
      prev = n;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({nibble, nibble_valid, word, word_valid, overflow, err_count} !== 47'd0) begin
        failures++;
        $display("FAIL reset_outputs got nib=%h nv=%b word=%h wv=%b ovf=%b err=%0d exp all zero",
                 nibble, nibble_valid, word, word_valid, overflow, err_count);
      end
    end
    rst = 1'b0;
    model_reset();
    nib_mark = obs_nib.size(); xfer_mark = obs_xfer.size(); v_mark = vcount;
  endtask

  task automatic test_reset();
    segments = 7'h00; word_ready = 1'b0;
    do_reset(3);
  endtask

  task automatic test_single();
    segments = 7'h00; do_reset(1);
    hold(7'h06, 9);
    @(negedge clk); #1;
    checks++;
    if (nibble_valid !== 1'b0 || obs_nib.size() != nib_mark) begin
      failures++; $display("FAIL single_early got nv=%b count=%0d exp nv=0 count=0", nibble_valid, obs_nib.size() - nib_mark);
    end
    hold(7'h06, 1);
    @(negedge clk); #1;
    checks++;
    if (nibble_valid !== 1'b1 || nibble !== 4'h1) begin
      failures++; $display("FAIL single_latency got nv=%b nib=%h exp nv=1 nib=1", nibble_valid, nibble);
    end
    hold(7'h06, 5);
    @(negedge clk); #1;
    checks++;
    if (obs_nib.size() - nib_mark != 1 || err_count !== 8'd0) begin
      failures++; $display("FAIL single_once got count=%0d err=%0d exp count=1 err=0", obs_nib.size() - nib_mark, err_count);
    end
  endtask

  task automatic test_word();
    segments = 7'h00; do_reset(1);
    word_ready = 1'b1;
    send_word(32'h12345678, 8);
    hold(7'h00, 3);
    @(negedge clk); #1;
    checks++;
    if (obs_xfer.size() - xfer_mark != 1) begin
      failures++; $display("FAIL word_count got=%0d exp=1", obs_xfer.size() - xfer_mark);
    end else begin
      checks++;
      if (obs_xfer[xfer_mark] !== 32'h12345678) begin
        failures++; $display("FAIL word_value got=%h exp=12345678", obs_xfer[xfer_mark]);
      end
    end
    checks++;
    if (vcount - v_mark != 1) begin
      failures++; $display("FAIL word_valid_cycles got=%0d exp=1", vcount - v_mark);
    end
  endtask

  task automatic test_blank_repeat();
    segments = 7'h00; do_reset(1);
    hold(7'h4F, 30); hold(7'h00, 12); hold(7'h4F, 12);
    @(negedge clk); #1;
    checks++;
    if (obs_nib.size() - nib_mark != 2) begin
      failures++; $display("FAIL blank_count got=%0d exp=2", obs_nib.size() - nib_mark);
    end else begin
      checks++;
      if (obs_nib[nib_mark] !== 4'h3 || obs_nib[nib_mark+1] !== 4'h3) begin
        failures++; $display("FAIL blank_values got=%h,%h exp=3,3", obs_nib[nib_mark], obs_nib[nib_mark+1]);
      end
    end
  endtask

  task automatic test_glitch_illegal();
    segments = 7'h00; do_reset(1);
    hold(7'h7F, 3); hold(7'h6F, 12);
    @(negedge clk); #1;
    checks++;
    if (obs_nib.size() - nib_mark != 1 || obs_nib[obs_nib.size()-1] !== 4'h9) begin
      failures++; $display("FAIL glitch got count=%0d exp count=1 nib=9", obs_nib.size() - nib_mark);
    end
    hold(7'h01, 12);
    @(negedge clk); #1;
    checks++;
    if (err_count !== 8'd1 || obs_nib.size() - nib_mark != 1) begin
      failures++; $display("FAIL illegal got err=%0d count=%0d exp err=1 count=1", err_count, obs_nib.size() - nib_mark);
    end
  endtask

  task automatic test_err_saturate();
    segments = 7'h00; do_reset(1);
    for (int i = 0; i < 260; i++) hold((i % 2 == 0) ? 7'h01 : 7'h02, 10);
    @(negedge clk); #1;
    checks++;
    if (err_count !== 8'd255 || obs_nib.size() != nib_mark) begin
      failures++; $display("FAIL err_saturate got=%0d exp=255", err_count);
    end
  endtask

  task automatic test_overflow();
    segments = 7'h00; word_ready = 1'b0; do_reset(1);
    send_word(32'hDEADBEEF, 8);
    send_word(32'h01234567, 8);
    @(negedge clk); #1;
    checks++;
    if (word !== 32'hDEADBEEF || word_valid !== 1'b1 || overflow !== 1'b1 || obs_xfer.size() != xfer_mark) begin
      failures++; $display("FAIL overflow_hold got word=%h wv=%b ovf=%b exp word=deadbeef wv=1 ovf=1", word, word_valid, overflow);
    end
    hold(segments, 1);
    word_ready = 1'b1;
    hold(segments, 3);
    @(negedge clk); #1;
    checks++;
    if (word_valid !== 1'b0 || obs_xfer.size() - xfer_mark != 1 || overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_drain got wv=%b xfers=%0d ovf=%b exp wv=0 xfers=1 ovf=1", word_valid, obs_xfer.size() - xfer_mark, overflow);
    end else begin
      checks++;
      if (obs_xfer[xfer_mark] !== 32'hDEADBEEF) begin
        failures++; $display("FAIL overflow_xfer got=%h exp=deadbeef", obs_xfer[xfer_mark]);
      end
    end
    send_word(32'h13579BDF, 8);
    hold(7'h00, 3);
    @(negedge clk); #1;
    checks++;
    if (obs_xfer.size() - xfer_mark != 2 || obs_xfer[obs_xfer.size()-1] !== 32'h13579BDF || overflow !== 1'b1 || word_valid !== 1'b0) begin
      failures++; $display("FAIL overflow_after got xfers=%0d last=%h ovf=%b exp xfers=2 last=13579bdf ovf=1", obs_xfer.size() - xfer_mark, obs_xfer[obs_xfer.size()-1], overflow);
    end
  endtask

  task automatic test_reset_midword();
    segments = 7'h00; word_ready = 1'b1; do_reset(1);
    send_word(32'hCAFEF00D, 5);
    segments = 7'h00;
    do_reset(3);
    send_word(32'h89ABCDEF, 8);
    hold(7'h00, 3);
    @(negedge clk); #1;
    checks++;
    if (obs_xfer.size() - xfer_mark != 1 || obs_xfer[obs_xfer.size()-1] !== 32'h89ABCDEF || word !== 32'h89ABCDEF) begin
      failures++; $display("FAIL reset_midword got xfers=%0d word=%h exp xfers=1 word=89abcdef", obs_xfer.size() - xfer_mark, word);
    end
  endtask

  task automatic test_held_across_reset();
    segments = 7'h00; do_reset(1);
    hold(7'h06, 12);
    do_reset(2);
    hold(7'h06, 12);
    @(negedge clk); #1;
    checks++;
    if (obs_nib.size() - nib_mark != 1 || obs_nib[obs_nib.size()-1] !== 4'h1) begin
      failures++; $display("FAIL held_across_reset got count=%0d exp count=1 nib=1", obs_nib.size() - nib_mark);
    end
  endtask

  task automatic test_random();
    int r;
    int n;
    logic [6:0] p;
    segments = 7'h00; word_ready = 1'b1; do_reset(1);
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55) p = seg_tab[$urandom_range(0, 15)];
      else if (r < 72) p = 7'h00;
      else if (r < 82) begin
        do p = 7'($urandom); while (decode(p) != -1);
      end else p = seg_tab[$urandom_range(0, 15)];
      n = (r >= 82) ? $urandom_range(1, 8) : $urandom_range(6, 14);
      hold(p, n);
      @(negedge clk); #1;
      checks++;
      if (word_valid !== m_hv || word !== m_hw || overflow !== m_ovf || err_count !== 8'(m_err)) begin
        failures++;
        $display("FAIL random_state it=%0d got wv=%b word=%h ovf=%b err=%0d exp wv=%b word=%h ovf=%b err=%0d",
                 it, word_valid, word, overflow, err_count, m_hv, m_hw, m_ovf, m_err);
      end
      hold(segments, 1);
      word_ready = 1'($urandom_range(0, 1));
    end
    word_ready = 1'b1;
    hold(7'h00, 12);
    @(negedge clk); #1;
    checks++;
    if (obs_nib.size() - nib_mark != exp_nib.size()) begin
      failures++; $display("FAIL random_nib_count got=%0d exp=%0d", obs_nib.size() - nib_mark, exp_nib.size());
    end else begin
      for (int i = 0; i < exp_nib.size(); i++) begin
        checks++;
        if (obs_nib[nib_mark+i] !== exp_nib[i]) begin
          failures++; $display("FAIL random_nib[%0d] got=%h exp=%h", i, obs_nib[nib_mark+i], exp_nib[i]);
        end
      end
    end
    checks++;
    if (obs_xfer.size() - xfer_mark != exp_xfer.size()) begin
      failures++; $display("FAIL random_xfer_count got=%0d exp=%0d", obs_xfer.size() - xfer_mark, exp_xfer.size());
    end else begin
      for (int i = 0; i < exp_xfer.size(); i++) begin
        checks++;
        if (obs_xfer[xfer_mark+i] !== exp_xfer[i]) begin
          failures++; $display("FAIL random_xfer[%0d] got=%h exp=%h", i, obs_xfer[xfer_mark+i], exp_xfer[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_word();
    test_blank_repeat();
    test_glitch_illegal();
    test_err_saturate();
    test_overflow();
    test_reset_midword();
    test_held_across_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
